rx_ber_checker: RTL and testbench

RX_BER_CHECKER -- requirements
Module: rx_ber_checker

---
 rtl/rx_ber_checker.sv | 160 ++++++++++++++++
 tb/tb_rx_ber_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ber_checker.sv
// rx_ber_checker: symbol decision and PRBS9 bit-error-rate checker.
// Samples a signed filter output at a selectable phase and decides each symbol from its sign.
// The decided bits are synchronised against a reference PRBS9 (x^9 + x^5 + 1) through the
// states SEARCH, CHECK and LOCKED.
// While LOCKED, every decision and every mismatch is counted in saturating counters.
module rx_ber_checker #(
    parameter int UPSAMPLE    = 4,
    parameter int IN_NBITS    = 8,
    parameter int CNT_NBITS   = 32,
    parameter int WIN         = 64,
    parameter int LOCK_THRESH = 2,
    parameter int LOSS_THRESH = 8,
    localparam int PH_NBITS   = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [IN_NBITS-1:0]  rx_in,
    input  logic [PH_NBITS-1:0]  phase_sel,
    input  logic                 clear,
    output logic                 bit_valid,
    output logic                 rx_bit,
    output logic                 locked,
    output logic [CNT_NBITS-1:0] bit_count,
    output logic [CNT_NBITS-1:0] err_count
);

    localparam int WC_NBITS = $clog2(WIN + 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [PH_NBITS-1:0]  pcnt_q, phase_q;
    logic [8:0]           lfsr_q, lfsr_d;
    logic [3:0]           search_q, search_d;
    logic [WC_NBITS-1:0]  win_cnt_q, win_cnt_d, win_err_q, win_err_d;
    logic [CNT_NBITS-1:0] bit_cnt_q, bit_cnt_d, err_cnt_q, err_cnt_d;
    logic                 bit_valid_q, rx_bit_q, locked_q;

    logic                 pcnt_wrap, dec_en, dec_bit, exp_bit, mismatch, win_end;
    logic [WC_NBITS-1:0]  win_err_tot;

    assign pcnt_wrap   = (pcnt_q == PH_NBITS'(UPSAMPLE - 1));
    // A decision is taken once per symbol, at the latched phase. Clear cancels it.
    assign dec_en      = enable && !clear && (pcnt_q == phase_q);
    assign dec_bit     = ~rx_in[IN_NBITS-1];
    assign exp_bit     = lfsr_q[8] ^ lfsr_q[4];
    assign mismatch    = dec_bit ^ exp_bit;
    assign win_end     = (win_cnt_q == WC_NBITS'(WIN - 1));
    // The WIN-th decision's own mismatch is included in the window evaluation.
    assign win_err_tot = win_err_q + WC_NBITS'(mismatch);

    // Phase counter, and a phase_sel latch that only updates at the period wrap.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            pcnt_q  <= '0;
            phase_q <= '0;
        end else if (clear) begin
            pcnt_q  <= '0;
        end else if (enable) begin
            if (pcnt_wrap) begin
                pcnt_q  <= '0;
                phase_q <= phase_sel;
            end else begin
                pcnt_q  <= pcnt_q + 1'b1;
            end
        end
    end

    // Next-state logic for the sync FSM, the reference LFSR, the window counters and the error counters.
    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can infer a latch.
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        search_d  = search_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        if (clear) begin
            state_d   = SEARCH;
            search_d  = '0;
            win_cnt_d = '0;
            win_err_d = '0;
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end else if (dec_en) begin
            case (state_q)
                SEARCH: begin
                    // Load the received bits as the LFSR seed.
                    lfsr_d = {lfsr_q[7:0], dec_bit};
                    if (search_q == 4'd8) begin
                        state_d   = CHECK;
                        search_d  = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        search_d  = search_q + 4'd1;
                    end
                end
                CHECK, LOCKED: begin
                    // The reference runs on its own prediction, so channel errors do not propagate into it.
                    lfsr_d    = {lfsr_q[7:0], exp_bit};
                    win_cnt_d = win_cnt_q + 1'b1;
                    win_err_d = win_err_tot;
                    if (state_q == LOCKED) begin
                        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
                        if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (win_end) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        search_d  = '0;
                        if (state_q == CHECK) begin
                            state_d = (32'(win_err_tot) <= LOCK_THRESH) ? LOCKED : SEARCH;
                        end else if (32'(win_err_tot) > LOSS_THRESH) begin
                            state_d = SEARCH;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // State and counter registers, plus the registered decision outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SEARCH;
            lfsr_q      <= '0;
            search_q    <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            bit_valid_q <= 1'b0;
            rx_bit_q    <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            search_q    <= search_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            bit_valid_q <= dec_en;
            locked_q    <= (state_d == LOCKED);
            if (dec_en) rx_bit_q <= dec_bit;
        end
    end

    assign bit_valid = bit_valid_q;
    assign rx_bit    = rx_bit_q;
    assign locked    = locked_q;
    assign bit_count = bit_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_rx_ber_checker.sv
// Directed testbench for rx_ber_checker.
// A sequence-level reference model (a queue holding the reference PRBS history) is
// compared against the DUT on every falling edge.
// Literal expectations at key points pin down the model itself.
module tb_rx_ber_checker;

    localparam int UPS  = 4;
    localparam int WIN  = 64;
    localparam int LOCK = 2;
    localparam int LOSS = 8;
    localparam int CNTW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  rx_in;
    logic [1:0]  phase_sel;
    logic        clear;
    logic        bit_valid, rx_bit, locked;
    logic [31:0] bit_count, err_count;

    int n_checks = 0;
    int n_fail   = 0;

    rx_ber_checker dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .rx_in     (rx_in),
        .phase_sel (phase_sel),
        .clear     (clear),
        .bit_valid (bit_valid),
        .rx_bit    (rx_bit),
        .locked    (locked),
        .bit_count (bit_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (sequence level) ----------------
    int      m_pc, m_ph, m_mode, m_wn, m_werr;   // m_mode: 0 search, 1 check, 2 locked
    bit      m_bv, m_rxb, m_lock;
    longint  m_bc, m_ec;
    bit      ref_q[$];
    bit      chk_en = 1'b0;
    localparam longint CNT_MAX = (64'd1 << CNTW) - 1;

    task automatic model_decide(input bit d);
        bit eb;
        m_bv  = 1'b1;
        m_rxb = d;
        if (m_mode == 0) begin
            ref_q.push_back(d);
            if (ref_q.size() == 9) begin
                m_mode = 1; m_wn = 0; m_werr = 0;
            end
        end else begin
            // reference bit n = bit(n-9) ^ bit(n-5)
            eb = ref_q[0] ^ ref_q[4];
            ref_q.push_back(eb);
            void'(ref_q.pop_front());
            m_wn++;
            if (d != eb) m_werr++;
            if (m_mode == 2) begin
                if (m_bc < CNT_MAX) m_bc++;
                if (d != eb && m_ec < CNT_MAX) m_ec++;
            end
            if (m_wn == WIN) begin
                if (m_mode == 1) m_mode = (m_werr <= LOCK) ? 2 : 0;
                else if (m_werr > LOSS) m_mode = 0;
                if (m_mode == 0) ref_q.delete();
                m_wn = 0; m_werr = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_pc = 0; m_ph = 0; m_mode = 0; m_wn = 0; m_werr = 0;
            m_bv = 0; m_rxb = 0; m_lock = 0; m_bc = 0; m_ec = 0;
            ref_q.delete();
        end else if (clear) begin
            m_pc = 0; m_mode = 0; m_wn = 0; m_werr = 0;
            m_bv = 0; m_lock = 0; m_bc = 0; m_ec = 0;
            ref_q.delete();
        end else begin
            m_bv = 0;
            if (enable) begin
                if (m_pc == m_ph) model_decide(~rx_in[7]);
                if (m_pc == UPS - 1) begin
                    m_pc = 0; m_ph = int'(phase_sel);
                end else begin
                    m_pc++;
                end
            end
            m_lock = (m_mode == 2);
        end
    end

    bit saw_lock;
    always @(negedge clk) begin
        if (chk_en) begin
            check("bit_valid", bit_valid, m_bv);
            check("rx_bit",    rx_bit,    m_rxb);
            check("locked",    locked,    m_lock);
            check("bit_count", bit_count, m_bc);
            check("err_count", err_count, m_ec);
            if (locked === 1'b1) saw_lock = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [8:0] g = 9'h1FF;   // transmit PRBS9 generator

    task automatic step(input logic en, input int val);
        enable = en;
        rx_in  = val[7:0];
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input bit b, input bit flip);
        bit v;
        v = b ^ flip;
        repeat (UPS) step(1'b1, v ? 100 : -100);
    endtask

    task automatic send_prbs(input int n, input int flip_lo, input int flip_hi);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = g[8] ^ g[4];
            g = {g[7:0], b};
            send_sym(b, (i >= flip_lo) && (i <= flip_hi));
        end
    endtask

    task automatic send_prbs_flips3(input int n, input int f0, input int f1, input int f2);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = g[8] ^ g[4];
            g = {g[7:0], b};
            send_sym(b, (i == f0) || (i == f1) || (i == f2));
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1'b0, 0);
        clear = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int pos [4];
        int pulses;
        rst = 1'b0; enable = 1'b0; rx_in = '0; phase_sel = 2'd2; clear = 1'b0;
        repeat (3) step(1'b0, 0);
        chk_en = 1'b1;
        check("reset bit_valid", bit_valid, 0);
        check("reset rx_bit",    rx_bit,    0);
        check("reset locked",    locked,    0);
        check("reset bit_count", bit_count, 0);
        check("reset err_count", err_count, 0);
        rst = 1'b1;

        // Alternating +64/-64 symbols, phase_sel=2. The latched phase is 0 until the first wrap.
        for (int k = 0; k < 24; k++) begin
            bit ebv;
            step(1'b1, ((k / 4) % 2 == 0) ? 64 : -64);
            ebv = (k < 4) ? (k == 0) : ((k % 4) == 2);
            check("alt bit_valid", bit_valid, ebv);
            if (ebv) check("alt rx_bit", rx_bit, ((k / 4) % 2 == 0));
        end

        // phase_sel changes mid-period; each new value applies from the next wrap.
        pos = '{2, 1, 3, 0};
        for (int p = 0; p < 4; p++) begin
            pulses = 0;
            for (int s = 0; s < 4; s++) begin
                if (p == 0 && s == 1) phase_sel = 2'd1;
                if (p == 1 && s == 2) phase_sel = 2'd3;
                if (p == 2 && s == 3) phase_sel = 2'd0;
                step(1'b1, (p % 2 == 0) ? 64 : -64);
                check("phase bit_valid", bit_valid, (s == pos[p]));
                if (bit_valid === 1'b1) pulses++;
            end
            check("pulses per period", pulses, 1);
        end

        // Clean PRBS9: lock after 9 + 64 decisions.
        phase_sel = 2'd2;
        pulse_clear();
        send_prbs(72, -1, -1);
        check("not locked at 72", locked, 0);
        send_prbs(1, -1, -1);
        check("locked at 73", locked, 1);
        check("bit_count at lock", bit_count, 0);
        send_prbs(10, -1, -1);
        check("bit_count +10", bit_count, 10);
        check("err_count clean", err_count, 0);

        // Three errors in one window: lock is kept.
        send_prbs_flips3(64, 5, 20, 40);
        check("err_count 3 flips", err_count, 3);
        check("locked after 3 flips", locked, 1);
        check("bit_count 74", bit_count, 74);

        // Clear, relock, then nine errors in one window: lock is lost at the window end.
        pulse_clear();
        check("clear locked", locked, 0);
        check("clear bit_count", bit_count, 0);
        check("clear err_count", err_count, 0);
        send_prbs(73, -1, -1);
        check("relocked", locked, 1);
        send_prbs(63, 0, 8);
        check("locked before window end", locked, 1);
        send_prbs(1, -1, -1);
        check("lock lost", locked, 0);
        check("err_count held 9", err_count, 9);
        check("bit_count held 64", bit_count, 64);

        // Relock, then reset while locked (reset wins over a simultaneous clear and enable).
        send_prbs(73, -1, -1);
        check("relocked 2", locked, 1);
        rst = 1'b0; clear = 1'b1;
        step(1'b1, 100);
        rst = 1'b1; clear = 1'b0;
        check("rst bit_valid", bit_valid, 0);
        check("rst rx_bit",    rx_bit,    0);
        check("rst locked",    locked,    0);
        check("rst bit_count", bit_count, 0);
        check("rst err_count", err_count, 0);

        // Relock, then clear on a decision cycle: the decision is suppressed.
        send_prbs(73, -1, -1);
        check("relocked 3", locked, 1);
        step(1'b1, 100);
        step(1'b1, 100);
        clear = 1'b1;
        step(1'b1, 100);
        clear = 1'b0;
        check("clear bit_valid", bit_valid, 0);
        check("clear locked 2", locked, 0);
        check("clear bit_count 2", bit_count, 0);

        // Random data: the checker must never lock.
        saw_lock = 1'b0;
        for (int i = 0; i < 10000; i++) send_sym(1'($urandom_range(0, 1)), 1'b0);
        check("random never locked", saw_lock, 0);
        check("random bit_count", bit_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
